// File: rtl/csi2tx_dphy_esc_pkg.sv
// Shared definitions for the D-PHY data-lane escape-mode receiver:
// LP line encodings, receiver FSM states and entry-command codes.
package csi2tx_dphy_esc_pkg;

  // Line state encoding is {dp, dn}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  typedef enum logic [3:0] {
    ST_STOP,
    ST_ENT_10,
    ST_ENT_00A,
    ST_ENT_01,
    ST_ENT_00B,
    ST_CMD,
    ST_LPDT,
    ST_ULPS,
    ST_ULPS_EXIT,
    ST_TRIG_HOLD,
    ST_ERR_WAIT
  } esc_state_e;

  localparam logic [7:0] CMD_LPDT       = 8'hE1;
  localparam logic [7:0] CMD_ULPS       = 8'h1E;
  localparam logic [7:0] CMD_RESET_TRIG = 8'h62;
  localparam logic [7:0] CMD_UNK3       = 8'h5D;
  localparam logic [7:0] CMD_UNK4       = 8'h21;
  localparam logic [7:0] CMD_UNK5       = 8'hA0;

  // One-hot trigger index for a command byte, zero when it is not a trigger
  function automatic logic [3:0] trig_decode(input logic [7:0] cmd);
    logic [3:0] t;
    t = 4'b0000;
    case (cmd)
      CMD_RESET_TRIG: t = 4'b0001;
      CMD_UNK3:       t = 4'b0010;
      CMD_UNK4:       t = 4'b0100;
      CMD_UNK5:       t = 4'b1000;
      default:        t = 4'b0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/csi2tx_dphy_lp_line_filter.sv
// Two-flop synchronizer plus stability filter for the LP DP/DN pair;
// publishes the accepted line state and a one-cycle strobe on each change.
module csi2tx_dphy_lp_line_filter
  import csi2tx_dphy_esc_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dp_i,
  input  logic       dn_i,
  output logic [1:0] line_o,
  output logic       event_o
);

  localparam int unsigned CW = 4;

  logic [1:0]    meta_q, sync_q, cand_q, line_q;
  logic [CW-1:0] cnt_q;
  logic          event_q;
  logic [CW:0]   run_c;

  // Length of the current run of identical samples, including this one
  assign run_c = (sync_q == cand_q && cnt_q != '0) ?
                 (CW+1)'(cnt_q) + (CW+1)'(1) : (CW+1)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= LP11;
      sync_q  <= LP11;
      cand_q  <= LP11;
      line_q  <= LP11;
      cnt_q   <= '0;
      event_q <= 1'b0;
    end else begin
      meta_q  <= {dp_i, dn_i};
      sync_q  <= meta_q;
      event_q <= 1'b0;
      if (sync_q == line_q) begin
        cnt_q <= '0;
      end else if (run_c >= (CW+1)'(STABLE_CYC)) begin
        line_q  <= sync_q;
        event_q <= 1'b1;
        cnt_q   <= '0;
      end else begin
        cand_q <= sync_q;
        cnt_q  <= run_c[CW-1:0];
      end
    end
  end

  assign line_o  = line_q;
  assign event_o = event_q;

endmodule

// File: rtl/csi2tx_dphy_dat_lane_esc_rx.sv
// Escape-mode receiver for one D-PHY data lane: entry detection, command
// decode, LPDT byte assembly, ULPS tracking and trigger reporting.
module csi2tx_dphy_dat_lane_esc_rx
  import csi2tx_dphy_esc_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic       clk_os,
  input  logic       reset,
  input  logic       lp_rx_dp,
  input  logic       lp_rx_dn,
  output logic       rx_stop_state,
  output logic       rx_esc_active,
  output logic       rx_lpdt_active,
  output logic [7:0] rx_lpdt_data,
  output logic       rx_lpdt_valid,
  output logic       rx_ulps_active,
  output logic [3:0] rx_trigger,
  output logic       err_esc,
  output logic       err_sync
);

  logic [1:0] line_c;
  logic       event_c;

  csi2tx_dphy_lp_line_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
    .clk     (clk_os),
    .reset   (reset),
    .dp_i    (lp_rx_dp),
    .dn_i    (lp_rx_dn),
    .line_o  (line_c),
    .event_o (event_c)
  );

  esc_state_e state_q;
  logic       mark_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       stop_q, esc_q, lpdt_q, ulps_q, valid_q, err_esc_q, err_sync_q;
  logic [7:0] data_q;
  logic [3:0] trig_q;

  logic       bit_c, is_mark_c;
  logic [7:0] cmd_c, byte_c;

  assign bit_c     = (line_c == LP10);
  assign is_mark_c = (line_c == LP10) || (line_c == LP01);
  assign cmd_c     = {shift_q[6:0], bit_c};
  assign byte_c    = {bit_c, shift_q[7:1]};

  always_ff @(posedge clk_os) begin
    if (reset) begin
      state_q    <= ST_STOP;
      mark_q     <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      stop_q     <= 1'b1;
      esc_q      <= 1'b0;
      lpdt_q     <= 1'b0;
      ulps_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      trig_q     <= '0;
      err_esc_q  <= 1'b0;
      err_sync_q <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      trig_q     <= '0;
      err_esc_q  <= 1'b0;
      err_sync_q <= 1'b0;
      if (event_c) begin
        case (state_q)
          ST_STOP: begin
            // LP-10 only starts entry when the line was idle at LP-11
            if (line_c == LP10 && stop_q) begin
              state_q <= ST_ENT_10;
              stop_q  <= 1'b0;
            end else begin
              stop_q <= (line_c == LP11);
            end
          end
          ST_ENT_10, ST_ENT_00A, ST_ENT_01: begin
            if (state_q == ST_ENT_10 && line_c == LP00) begin
              state_q <= ST_ENT_00A;
            end else if (state_q == ST_ENT_00A && line_c == LP01) begin
              state_q <= ST_ENT_01;
            end else if (state_q == ST_ENT_01 && line_c == LP00) begin
              state_q   <= ST_ENT_00B;
              esc_q     <= 1'b1;
              mark_q    <= 1'b0;
              bit_cnt_q <= '0;
            end else if (line_c == LP11) begin
              state_q <= ST_STOP;
              stop_q  <= 1'b1;
            end else begin
              state_q   <= ST_ERR_WAIT;
              err_esc_q <= 1'b1;
            end
          end
          ST_ENT_00B, ST_CMD, ST_LPDT: begin
            if (line_c == LP11) begin
              state_q    <= ST_STOP;
              stop_q     <= 1'b1;
              esc_q      <= 1'b0;
              lpdt_q     <= 1'b0;
              err_sync_q <= (bit_cnt_q != '0);
            end else if (is_mark_c && !mark_q) begin
              mark_q    <= 1'b1;
              bit_cnt_q <= 3'(bit_cnt_q + 3'd1);
              if (state_q == ST_LPDT) begin
                shift_q <= byte_c;
                if (bit_cnt_q == 3'd7) begin
                  data_q  <= byte_c;
                  valid_q <= 1'b1;
                end
              end else begin
                shift_q <= cmd_c;
                state_q <= ST_CMD;
                if (bit_cnt_q == 3'd7) begin
                  if (cmd_c == CMD_LPDT) begin
                    state_q <= ST_LPDT;
                    lpdt_q  <= 1'b1;
                  end else if (cmd_c == CMD_ULPS) begin
                    state_q <= ST_ULPS;
                    ulps_q  <= 1'b1;
                  end else if (trig_decode(cmd_c) != 4'b0000) begin
                    state_q <= ST_TRIG_HOLD;
                    trig_q  <= trig_decode(cmd_c);
                  end else begin
                    state_q   <= ST_ERR_WAIT;
                    err_esc_q <= 1'b1;
                  end
                end
              end
            end else if (line_c == LP00 && mark_q) begin
              mark_q <= 1'b0;
            end else begin
              state_q   <= ST_ERR_WAIT;
              err_esc_q <= 1'b1;
            end
          end
          ST_ULPS: begin
            if (line_c == LP10) state_q <= ST_ULPS_EXIT;
          end
          ST_ULPS_EXIT: begin
            if (line_c == LP11) begin
              state_q <= ST_STOP;
              stop_q  <= 1'b1;
              ulps_q  <= 1'b0;
              esc_q   <= 1'b0;
            end else begin
              state_q <= ST_ULPS;
            end
          end
          ST_TRIG_HOLD, ST_ERR_WAIT: begin
            if (line_c == LP11) begin
              state_q <= ST_STOP;
              stop_q  <= 1'b1;
              esc_q   <= 1'b0;
              lpdt_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_STOP;
            stop_q  <= (line_c == LP11);
          end
        endcase
      end
    end
  end

  assign rx_stop_state  = stop_q;
  assign rx_esc_active  = esc_q;
  assign rx_lpdt_active = lpdt_q;
  assign rx_lpdt_data   = data_q;
  assign rx_lpdt_valid  = valid_q;
  assign rx_ulps_active = ulps_q;
  assign rx_trigger     = trig_q;
  assign err_esc        = err_esc_q;
  assign err_sync       = err_sync_q;

endmodule

// File: tb/tb_csi2tx_dphy_dat_lane_esc_rx.sv
// Directed bench for the escape-mode receiver: a scenario table of
// escape transactions plus hand sequences for ULPS, glitch and reset.
module tb_csi2tx_dphy_dat_lane_esc_rx;

  localparam logic [1:0] L11 = 2'b11;
  localparam logic [1:0] L10 = 2'b10;
  localparam logic [1:0] L01 = 2'b01;
  localparam logic [1:0] L00 = 2'b00;
  localparam int H = 10;

  logic       clk_os = 1'b0;
  logic       reset;
  logic       lp_rx_dp, lp_rx_dn;
  logic       rx_stop_state, rx_esc_active, rx_lpdt_active, rx_lpdt_valid;
  logic       rx_ulps_active, err_esc, err_sync;
  logic [7:0] rx_lpdt_data;
  logic [3:0] rx_trigger;

  always #5 clk_os = ~clk_os;

  csi2tx_dphy_dat_lane_esc_rx #(.STABLE_CYC(4)) dut (
    .clk_os         (clk_os),
    .reset          (reset),
    .lp_rx_dp       (lp_rx_dp),
    .lp_rx_dn       (lp_rx_dn),
    .rx_stop_state  (rx_stop_state),
    .rx_esc_active  (rx_esc_active),
    .rx_lpdt_active (rx_lpdt_active),
    .rx_lpdt_data   (rx_lpdt_data),
    .rx_lpdt_valid  (rx_lpdt_valid),
    .rx_ulps_active (rx_ulps_active),
    .rx_trigger     (rx_trigger),
    .err_esc        (err_esc),
    .err_sync       (err_sync)
  );

  int total = 0;
  int bad   = 0;

  // Pulse monitor: cumulative counts, sampled on the falling edge
  int         n_valid = 0, n_esc = 0, n_sync = 0, n_trig = 0, n_lpdt = 0, n_act = 0;
  logic [3:0] last_trig = '0;
  logic [7:0] dq[$];

  always @(negedge clk_os) begin
    if (rx_lpdt_valid) begin
      n_valid++;
      dq.push_back(rx_lpdt_data);
    end
    if (err_esc) n_esc++;
    if (err_sync) n_sync++;
    if (rx_trigger != 4'b0000) begin
      n_trig++;
      last_trig = rx_trigger;
    end
    if (rx_lpdt_active) n_lpdt++;
    if (rx_esc_active) n_act++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input int n);
    {lp_rx_dp, lp_rx_dn} = s;
    repeat (n) @(negedge clk_os);
  endtask

  task automatic send_bit(input logic b);
    drive(b ? L10 : L01, H);
    drive(L00, H);
  endtask

  task automatic send_entry();
    drive(L10, H);
    drive(L00, H);
    drive(L01, H);
    drive(L00, H);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic send_data(input logic [31:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [31:0] data;
    int          nbits;
    int          exp_valid;
    logic [7:0]  exp_d0;
    logic [7:0]  exp_d1;
    int          exp_esc;
    int          exp_sync;
    int          exp_trig;
    logic [3:0]  exp_tv;
    int          exp_lpdt;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [7:0] c, input logic [31:0] d,
                              input int nb, input int v, input logic [7:0] d0, input logic [7:0] d1,
                              input int e, input int s, input int t, input logic [3:0] tv, input int lp);
    vec_t r;
    r.name = nm; r.cmd = c; r.data = d; r.nbits = nb; r.exp_valid = v;
    r.exp_d0 = d0; r.exp_d1 = d1; r.exp_esc = e; r.exp_sync = s;
    r.exp_trig = t; r.exp_tv = tv; r.exp_lpdt = lp;
    return r;
  endfunction

  vec_t tbl[8];

  initial begin
    int b_valid, b_esc, b_sync, b_trig, b_lpdt, b_act, b_dq;

    tbl[0] = mk("lpdt_a5_3c", 8'hE1, 32'h3CA5, 16, 2, 8'hA5, 8'h3C, 0, 0, 0, 4'h0, 1);
    tbl[1] = mk("reset_trig", 8'h62, 32'h0,     0, 0, 8'h00, 8'h00, 0, 0, 1, 4'h1, 0);
    tbl[2] = mk("lpdt_5bit",  8'hE1, 32'h15,    5, 0, 8'h00, 8'h00, 0, 1, 0, 4'h0, 1);
    tbl[3] = mk("bad_cmd_ff", 8'hFF, 32'h0,     0, 0, 8'h00, 8'h00, 1, 0, 0, 4'h0, 0);
    tbl[4] = mk("unk3",       8'h5D, 32'h0,     0, 0, 8'h00, 8'h00, 0, 0, 1, 4'h2, 0);
    tbl[5] = mk("unk4",       8'h21, 32'h0,     0, 0, 8'h00, 8'h00, 0, 0, 1, 4'h4, 0);
    tbl[6] = mk("unk5",       8'hA0, 32'h0,     0, 0, 8'h00, 8'h00, 0, 0, 1, 4'h8, 0);
    tbl[7] = mk("lpdt_ff",    8'hE1, 32'hFF,    8, 1, 8'hFF, 8'h00, 0, 0, 0, 4'h0, 1);

    reset = 1'b1;
    {lp_rx_dp, lp_rx_dn} = L11;
    @(negedge clk_os);
    repeat (4) @(negedge clk_os);
    reset = 1'b0;
    repeat (20) @(negedge clk_os);

    chk("rst_stop",  32'(rx_stop_state),  32'd1);
    chk("rst_esc",   32'(rx_esc_active),  32'd0);
    chk("rst_lpdt",  32'(rx_lpdt_active), 32'd0);
    chk("rst_data",  32'(rx_lpdt_data),   32'd0);
    chk("rst_valid", 32'(n_valid),        32'd0);
    chk("rst_ulps",  32'(rx_ulps_active), 32'd0);
    chk("rst_trig",  32'(n_trig),         32'd0);
    chk("rst_errs",  32'(n_esc + n_sync), 32'd0);

    foreach (tbl[k]) begin
      b_valid = n_valid; b_esc = n_esc; b_sync = n_sync;
      b_trig = n_trig; b_lpdt = n_lpdt; b_act = n_act; b_dq = dq.size();
      send_entry();
      send_cmd(tbl[k].cmd);
      send_data(tbl[k].data, tbl[k].nbits);
      drive(L11, 20);
      chk({tbl[k].name, ".valid"},  32'(n_valid - b_valid), 32'(tbl[k].exp_valid));
      if (tbl[k].exp_valid > 0 && dq.size() > b_dq)
        chk({tbl[k].name, ".d0"}, 32'(dq[b_dq]), 32'(tbl[k].exp_d0));
      if (tbl[k].exp_valid > 1 && dq.size() > b_dq + 1)
        chk({tbl[k].name, ".d1"}, 32'(dq[b_dq + 1]), 32'(tbl[k].exp_d1));
      chk({tbl[k].name, ".err_esc"},  32'(n_esc - b_esc),   32'(tbl[k].exp_esc));
      chk({tbl[k].name, ".err_sync"}, 32'(n_sync - b_sync), 32'(tbl[k].exp_sync));
      chk({tbl[k].name, ".trig_cyc"}, 32'(n_trig - b_trig), 32'(tbl[k].exp_trig));
      if (tbl[k].exp_trig > 0)
        chk({tbl[k].name, ".trig_val"}, 32'(last_trig), 32'(tbl[k].exp_tv));
      chk({tbl[k].name, ".lpdt_seen"}, 32'((n_lpdt - b_lpdt) > 0), 32'(tbl[k].exp_lpdt));
      chk({tbl[k].name, ".esc_seen"},  32'((n_act - b_act) > 0), 32'd1);
      chk({tbl[k].name, ".end_stop"},  32'(rx_stop_state), 32'd1);
      chk({tbl[k].name, ".end_esc"},   32'(rx_esc_active), 32'd0);
      chk({tbl[k].name, ".end_lpdt"},  32'(rx_lpdt_active), 32'd0);
    end
    chk("lpdt_data_reg", 32'(rx_lpdt_data), 32'hFF);

    // ULPS: long LP-00 hold, then exit; check exact drop latency
    b_esc = n_esc; b_sync = n_sync;
    send_entry();
    send_cmd(8'h1E);
    drive(L00, 200);
    chk("ulps.hold",   32'(rx_ulps_active), 32'd1);
    chk("ulps.esc",    32'(rx_esc_active),  32'd1);
    chk("ulps.stop",   32'(rx_stop_state),  32'd0);
    drive(L10, H);
    chk("ulps.exit10", 32'(rx_ulps_active), 32'd1);
    drive(L11, 6);
    chk("ulps.before", 32'(rx_ulps_active), 32'd1);
    drive(L11, 1);
    chk("ulps.drop",   32'(rx_ulps_active), 32'd0);
    chk("ulps.stop2",  32'(rx_stop_state),  32'd1);
    chk("ulps.esc2",   32'(rx_esc_active),  32'd0);
    chk("ulps.errs",   32'((n_esc - b_esc) + (n_sync - b_sync)), 32'd0);
    drive(L11, 10);

    // One-cycle dp glitch on LP-00 must not shift the command framing
    b_valid = n_valid; b_esc = n_esc; b_sync = n_sync; b_dq = dq.size();
    send_entry();
    drive(L10, 1);
    drive(L00, H);
    send_cmd(8'hE1);
    send_data(32'h5A, 8);
    drive(L11, 20);
    chk("glitch.valid", 32'(n_valid - b_valid), 32'd1);
    if (dq.size() > b_dq) chk("glitch.data", 32'(dq[b_dq]), 32'h5A);
    chk("glitch.err_esc",  32'(n_esc - b_esc),   32'd0);
    chk("glitch.err_sync", 32'(n_sync - b_sync), 32'd0);

    // Reset in the middle of an LPDT byte discards it silently
    b_valid = n_valid; b_sync = n_sync;
    send_entry();
    send_cmd(8'hE1);
    send_data(32'h7, 3);
    chk("midrst.lpdt_pre", 32'(rx_lpdt_active), 32'd1);
    reset = 1'b1;
    {lp_rx_dp, lp_rx_dn} = L11;
    repeat (3) @(negedge clk_os);
    reset = 1'b0;
    repeat (20) @(negedge clk_os);
    chk("midrst.lpdt",  32'(rx_lpdt_active), 32'd0);
    chk("midrst.esc",   32'(rx_esc_active),  32'd0);
    chk("midrst.stop",  32'(rx_stop_state),  32'd1);
    chk("midrst.sync",  32'(n_sync - b_sync), 32'd0);
    chk("midrst.valid", 32'(n_valid - b_valid), 32'd0);

    // Turnaround request LP-01 from STOP drops stop state only
    drive(L01, 20);
    chk("ta.stop", 32'(rx_stop_state), 32'd0);
    chk("ta.esc",  32'(rx_esc_active), 32'd0);
    drive(L11, 20);
    chk("ta.back", 32'(rx_stop_state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
